alu_result_collector: RTL and testbench



---
 rtl/alu_result_collector_if.sv | 48 ++++
 rtl/alu_result_collector.sv | 153 +++++++++++++++
 tb/tb_alu_result_collector.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_collector_if.sv
// ---------------------------------------------------------------------------
// alu_result_collector_if
//
// Bundles the signals between the ALU sub-units and alu_result_collector.
//   master : ALU side. Drives ALU_EN/ALU_FUN/UNIT_OUT/UNIT_DONE and observes
//            the registered result.
//   slave  : the collector. Samples the unit bus and drives
//            ALU_OUT/OUT_VALID/BUSY/TIMEOUT_ERR.
//
// Handshake: ALU_EN is a one-cycle start strobe and is only honoured while
// the collector is idle (BUSY low). There is no back-pressure. OUT_VALID is a
// one-cycle pulse; the consumer must take ALU_OUT in that cycle.
//
// Optional macro ALU_OUT_PARITY_EN adds OUT_PARITY (even parity of ALU_OUT).
// ---------------------------------------------------------------------------
interface alu_result_collector_if #(
  parameter int WIDTH     = 16,
  parameter int NUM_UNITS = 4,
  parameter int SEL_WIDTH = 2
);
  logic                       ALU_EN;
  logic [SEL_WIDTH-1:0]       ALU_FUN;
  logic [NUM_UNITS*WIDTH-1:0] UNIT_OUT;
  logic [NUM_UNITS-1:0]       UNIT_DONE;
  logic [WIDTH-1:0]           ALU_OUT;
  logic                       OUT_VALID;
  logic                       BUSY;
  logic                       TIMEOUT_ERR;
`ifdef ALU_OUT_PARITY_EN
  logic                       OUT_PARITY;
`endif

  modport master (
    output ALU_EN, ALU_FUN, UNIT_OUT, UNIT_DONE,
    input  ALU_OUT, OUT_VALID, BUSY, TIMEOUT_ERR
`ifdef ALU_OUT_PARITY_EN
    , input OUT_PARITY
`endif
  );

  modport slave (
    input  ALU_EN, ALU_FUN, UNIT_OUT, UNIT_DONE,
    output ALU_OUT, OUT_VALID, BUSY, TIMEOUT_ERR
`ifdef ALU_OUT_PARITY_EN
    , output OUT_PARITY
`endif
  );
endinterface

// File: rtl/alu_result_collector.sv
// ---------------------------------------------------------------------------
// alu_result_collector
//
// Collects the result of one of NUM_UNITS ALU sub-units. On a start strobe
// the selected unit's result is registered at once if its done flag is
// already high; otherwise the select is latched and the block waits for that
// unit's done flag. A watchdog ends the wait after TIMEOUT cycles with a zero
// result and a TIMEOUT_ERR pulse. Illegal selects return zero immediately.
//
// Ports:
//   CLK       : clock, rising edge
//   RST       : asynchronous active-low reset
//   bus       : alu_result_collector_if.slave (unit bus in, result out)
//   dbg_state : current FSM state (0 = IDLE, 1 = WAIT)
//
// Optional macro ALU_OUT_PARITY_EN: adds registered even parity OUT_PARITY.
// ---------------------------------------------------------------------------
module alu_result_collector #(
  parameter int WIDTH     = 16,
  parameter int NUM_UNITS = 4,
  parameter int SEL_WIDTH = 2,
  parameter int TIMEOUT   = 15,
  parameter int TO_WIDTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  alu_result_collector_if.slave  bus,
  output logic                   dbg_state
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  // Selects are padded to a power of two so any ALU_FUN value indexes safely.
  localparam int SEL_SPAN = 2 ** SEL_WIDTH;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  function automatic logic [SEL_SPAN-1:0] legal_mask();
    logic [SEL_SPAN-1:0] m;
    for (int k = 0; k < SEL_SPAN; k++) m[k] = (k < NUM_UNITS);
    return m;
  endfunction

  localparam logic [SEL_SPAN-1:0] LEGAL = legal_mask();

  logic                 state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [TO_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 terr_q, terr_d;

  logic [SEL_SPAN-1:0]  done_pad;
  logic [WIDTH-1:0]     slice [SEL_SPAN];

  always_comb begin
    done_pad = '0;
    done_pad[NUM_UNITS-1:0] = bus.UNIT_DONE;
    for (int k = 0; k < SEL_SPAN; k++) slice[k] = '0;
    for (int k = 0; k < NUM_UNITS; k++) slice[k] = bus.UNIT_OUT[k*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    terr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ALU_EN) begin
          if (!LEGAL[bus.ALU_FUN]) begin
            out_d   = '0;
            valid_d = 1'b1;
          end else if (done_pad[bus.ALU_FUN]) begin
            out_d   = slice[bus.ALU_FUN];
            valid_d = 1'b1;
          end else begin
            sel_d   = bus.ALU_FUN;
            cnt_d   = '0;
            state_d = ST_WAIT;
            busy_d  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Done wins over the watchdog in the same cycle.
        if (done_pad[sel_q]) begin
          out_d   = slice[sel_q];
          valid_d = 1'b1;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          out_d   = '0;
          valid_d = 1'b1;
          terr_d  = 1'b1;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.ALU_OUT     = out_q;
  assign bus.OUT_VALID   = valid_q;
  assign bus.BUSY        = busy_q;
  assign bus.TIMEOUT_ERR = terr_q;
  assign dbg_state       = state_q;

`ifdef ALU_OUT_PARITY_EN
  logic parity_q, parity_d;

  // Follows the next ALU_OUT value, so a zero (timeout/illegal) result gives 0.
  always_comb parity_d = ^out_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) parity_q <= 1'b0;
    else      parity_q <= parity_d;
  end

  assign bus.OUT_PARITY = parity_q;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
module tb_alu_result_collector;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int TO = 15;
  localparam int TW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_collector_if #(.WIDTH(W), .NUM_UNITS(N), .SEL_WIDTH(S)) bus ();
  alu_result_collector_if #(.WIDTH(W), .NUM_UNITS(3), .SEL_WIDTH(S)) bus3 ();
  logic dbg_state, dbg_state3;

  alu_result_collector #(.WIDTH(W), .NUM_UNITS(N), .SEL_WIDTH(S), .TIMEOUT(TO), .TO_WIDTH(TW)) dut (
    .CLK(clk), .RST(rst_n), .bus(bus), .dbg_state(dbg_state));

  alu_result_collector #(.WIDTH(W), .NUM_UNITS(3), .SEL_WIDTH(S), .TIMEOUT(TO), .TO_WIDTH(TW)) dut3 (
    .CLK(clk), .RST(rst_n), .bus(bus3), .dbg_state(dbg_state3));

  // ---------------- scoreboard / counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: an operation is either resolved on the spot or becomes
  // "pending" and ages one step per cycle until its unit is done or it has
  // waited TIMEOUT cycles.
  bit           m_pending;
  int           m_sel;
  int           m_age;
  logic [W-1:0] m_out;
  bit           m_valid, m_terr;

  function automatic logic [W-1:0] unit_val(int k);
    return bus.UNIT_OUT[k*W +: W];
  endfunction

  task automatic model_reset();
    m_pending = 0; m_sel = 0; m_age = 0;
    m_out = '0; m_valid = 0; m_terr = 0;
    exp_q.delete();
  endtask

  task automatic deliver(input logic [W-1:0] v, input bit to);
    m_out = v; m_valid = 1; m_terr = to;
    exp_q.push_back(v);
  endtask

  task automatic model_step();
    m_valid = 0; m_terr = 0;
    if (!m_pending) begin
      if (bus.ALU_EN) begin
        if (int'(bus.ALU_FUN) >= N)            deliver('0, 0);
        else if (bus.UNIT_DONE[bus.ALU_FUN])   deliver(unit_val(int'(bus.ALU_FUN)), 0);
        else begin m_pending = 1; m_sel = int'(bus.ALU_FUN); m_age = 0; end
      end
    end else begin
      m_age++;
      if (bus.UNIT_DONE[m_sel])  begin deliver(unit_val(m_sel), 0); m_pending = 0; end
      else if (m_age == TO)      begin deliver('0, 1);              m_pending = 0; end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are set between edges; one call advances one clock and checks.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("valid", bus.OUT_VALID, m_valid);
    check("busy", bus.BUSY, m_pending);
    check("terr", bus.TIMEOUT_ERR, m_terr);
    check("out_hold", bus.ALU_OUT, m_out);
`ifdef ALU_OUT_PARITY_EN
    check("parity", bus.OUT_PARITY, ^m_out);
`endif
    if (bus.OUT_VALID) begin
      if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
      else                   check("sb_out", bus.ALU_OUT, exp_q.pop_front());
    end
  endtask

  task automatic drive(input bit en, input int fun, input logic [N-1:0] done);
    bus.ALU_EN = en; bus.ALU_FUN = S'(fun); bus.UNIT_DONE = done;
  endtask

  task automatic set_unit(input int k, input logic [W-1:0] v);
    bus.UNIT_OUT[k*W +: W] = v;
  endtask

  int busy_cnt;

  initial begin
    bus.ALU_EN = 0; bus.ALU_FUN = '0; bus.UNIT_DONE = '0; bus.UNIT_OUT = '0;
    bus3.ALU_EN = 0; bus3.ALU_FUN = '0; bus3.UNIT_DONE = '0; bus3.UNIT_OUT = '0;
    model_reset();

    // ---- reset values ----
    #12;
    check("rst_out", bus.ALU_OUT, 0);
    check("rst_valid", bus.OUT_VALID, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_terr", bus.TIMEOUT_ERR, 0);
    #5 rst_n = 1'b1;

    // ---- fast path ----
    for (int k = 0; k < N; k++) set_unit(k, W'($urandom));
    set_unit(1, 16'hA5A5);
    drive(1, 1, 4'b0010);
    cycle();
    check("fast_out", bus.ALU_OUT, 16'hA5A5);
    check("fast_valid", bus.OUT_VALID, 1);
    check("fast_busy", bus.BUSY, 0);
    drive(0, 0, '0);
    cycle();
    check("fast_valid_drop", bus.OUT_VALID, 0);

    // ---- wait path: done three cycles after start ----
    set_unit(3, 16'h0F00);
    drive(1, 3, '0);
    busy_cnt = 0;
    cycle(); busy_cnt += int'(bus.BUSY);
    drive(0, 1, 4'b0010);                    // other unit's done is ignored
    cycle(); busy_cnt += int'(bus.BUSY);
    cycle(); busy_cnt += int'(bus.BUSY);
    drive(0, 0, 4'b1000);
    cycle(); busy_cnt += int'(bus.BUSY);
    check("wait_busy_cycles", busy_cnt, 3);
    check("wait_out", bus.ALU_OUT, 16'h0F00);
    check("wait_valid", bus.OUT_VALID, 1);
    drive(0, 0, '0);
    cycle();

    // ---- timeout ----
    drive(1, 2, '0);
    busy_cnt = 0;
    cycle(); busy_cnt += int'(bus.BUSY);
    drive(0, 0, '0);
    for (int i = 0; i < TO; i++) begin cycle(); busy_cnt += int'(bus.BUSY); end
    check("to_busy_cycles", busy_cnt, TO);
    check("to_valid", bus.OUT_VALID, 1);
    check("to_terr", bus.TIMEOUT_ERR, 1);
    check("to_out", bus.ALU_OUT, 0);
    cycle();
    check("to_terr_drop", bus.TIMEOUT_ERR, 0);

    // ---- done in the last WAIT cycle beats the watchdog ----
    set_unit(2, 16'h3C3C);
    drive(1, 2, '0);
    cycle();
    drive(0, 0, '0);
    for (int i = 0; i < TO - 1; i++) cycle();
    drive(0, 0, 4'b0100);
    cycle();
    check("edge_valid", bus.OUT_VALID, 1);
    check("edge_terr", bus.TIMEOUT_ERR, 0);
    check("edge_out", bus.ALU_OUT, 16'h3C3C);
    drive(0, 0, '0);
    cycle();

    // ---- illegal select on a 3-unit instance ----
    bus3.UNIT_OUT[0 +: W] = 16'h1234;
    bus3.ALU_EN = 1; bus3.ALU_FUN = 2'd0; bus3.UNIT_DONE = 3'b001;
    cycle();
    check("n3_fast_out", bus3.ALU_OUT, 16'h1234);
    bus3.ALU_FUN = 2'd3; bus3.UNIT_DONE = 3'b000;
    cycle();
    check("n3_ill_out", bus3.ALU_OUT, 0);
    check("n3_ill_valid", bus3.OUT_VALID, 1);
    check("n3_ill_terr", bus3.TIMEOUT_ERR, 0);
    check("n3_ill_busy", bus3.BUSY, 0);
    bus3.ALU_EN = 0;
    cycle();
    check("n3_ill_busy2", bus3.BUSY, 0);

    // ---- reset in the middle of WAIT ----
    drive(1, 1, '0);
    cycle();
    drive(0, 0, '0);
    cycle();
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.BUSY, 0);
    check("mid_rst_out", bus.ALU_OUT, 0);
    check("mid_rst_valid", bus.OUT_VALID, 0);
    #1 rst_n = 1'b1;
    model_reset();
    set_unit(0, 16'h0001);
    drive(1, 0, 4'b0001);
    cycle();
    check("post_rst_out", bus.ALU_OUT, 16'h0001);
    check("post_rst_valid", bus.OUT_VALID, 1);
`ifdef ALU_OUT_PARITY_EN
    check("post_rst_parity", bus.OUT_PARITY, 1);
`endif
    drive(0, 0, 4'b0010);
    cycle();
    check("post_rst_no_stale", bus.OUT_VALID, 0);

    // ---- randomized traffic ----
    for (int i = 0; i < 1500; i++) begin
      bit quiet;
      logic [N-1:0] d;
      quiet = ((i / 80) % 3) == 2;           // stretches with no done at all
      for (int k = 0; k < N; k++) begin
        set_unit(k, W'($urandom));
        d[k] = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
      end
      drive($urandom_range(0, 1), $urandom_range(0, N - 1), d);
      cycle();
    end
    drive(0, 0, '0);
    for (int i = 0; i < TO + 2; i++) cycle();
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout_guard got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
